bin2bcd_8421_seq: RTL and testbench

//   Sequential binary-to-8421-BCD converter using shift-and-add-3 (double dabble).

---
 rtl/bcd_pkg.sv | 18 +
 rtl/bcd_add3_digit.sv | 12 +
 rtl/bin2bcd_8421_seq.sv | 107 ++++++++++
 tb/tb_bin2bcd_8421_seq.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion path: digit width,
// converter FSM states and a helper that sizes the BCD output for a given binary width.
package bcd_pkg;

   localparam int BCD_DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // 2**n - 1 has as many decimal digits as 2**n, i.e. floor(n*log10(2)) + 1.
   function automatic int bcd_digits(input int bin_w);
      return (bin_w * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets +3 before the
// shift, so that doubling it carries correctly into the next decimal digit.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit_i,
   output logic [BCD_DIGIT_W-1:0] digit_o
);

   assign digit_o = (digit_i >= BCD_DIGIT_W'(5)) ? digit_i + BCD_DIGIT_W'(3) : digit_i;

endmodule

// File: rtl/bin2bcd_8421_seq.sv
// Sequential binary to 8421 BCD converter (shift-and-add-3), one bit per cycle,
// valid/ready on both sides with a single conversion in flight.
module bin2bcd_8421_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 16,
   parameter int DIGITS = 5,
   parameter int CNT_W  = 5
)
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [BIN_W-1:0]                bin_in,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd_out,
   output logic                            out_ovf
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;

   state_e            state_q,   state_d;
   logic [BIN_W-1:0]  bin_sh_q,  bin_sh_d;
   logic [BCD_W-1:0]  bcd_sh_q,  bcd_sh_d;
   logic [BCD_W-1:0]  bcd_out_q, bcd_out_d;
   logic              ovf_q,     ovf_d;
   logic              out_ovf_q, out_ovf_d;
   logic [CNT_W-1:0]  cnt_q,     cnt_d;
   logic [BCD_W-1:0]  bcd_adj;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         bcd_add3_digit u_add3 (
            .digit_i (bcd_sh_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (bcd_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
         );
      end
   endgenerate

   always_comb begin
      state_d   = state_q;
      bin_sh_d  = bin_sh_q;
      bcd_sh_d  = bcd_sh_q;
      bcd_out_d = bcd_out_q;
      ovf_d     = ovf_q;
      out_ovf_d = out_ovf_q;
      cnt_d     = cnt_q;
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_sh_d = bin_in;
               bcd_sh_d = '0;
               ovf_d    = 1'b0;
               cnt_d    = CNT_W'(BIN_W);
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            // A set bit leaving the top digit means the value cannot fit in DIGITS digits.
            bcd_sh_d = {bcd_adj[BCD_W-2:0], bin_sh_q[BIN_W-1]};
            bin_sh_d = bin_sh_q << 1;
            ovf_d    = ovf_q | bcd_adj[BCD_W-1];
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_out_d = bcd_sh_d;
               out_ovf_d = ovf_d;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         bin_sh_q  <= '0;
         bcd_sh_q  <= '0;
         bcd_out_q <= '0;
         ovf_q     <= 1'b0;
         out_ovf_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         bin_sh_q  <= bin_sh_d;
         bcd_sh_q  <= bcd_sh_d;
         bcd_out_q <= bcd_out_d;
         ovf_q     <= ovf_d;
         out_ovf_q <= out_ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bcd_out = bcd_out_q;
   assign out_ovf = out_ovf_q;

endmodule

// File: tb/tb_bin2bcd_8421_seq.sv
// Scoreboard bench for bin2bcd_8421_seq: a 16-bit/5-digit instance and an
// 8-bit/2-digit instance, checked against a decimal arithmetic model.
module tb_bin2bcd_8421_seq;

   typedef struct {
      logic [19:0] bcd;
      bit          ovf;
      longint      val;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        in_valid_a = 1'b0, in_ready_a, out_valid_a, out_ovf_a;
   logic [15:0] bin_in_a = '0;
   logic [19:0] bcd_out_a;
   logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ovf_b;
   logic [7:0]  bin_in_b = '0;
   logic [7:0]  bcd_out_b;
   logic        out_ready_b = 1'b1;

   logic        rand_mode = 1'b0;
   logic        out_ready_dir = 1'b1;
   logic        out_ready_rnd = 1'b1;
   logic        out_ready_a;
   assign out_ready_a = rand_mode ? out_ready_rnd : out_ready_dir;

   int   n_vec  = 0;
   int   n_miss = 0;
   int   cyc    = 0;
   bit   prev_va = 1'b0, prev_vb = 1'b0;
   exp_t qa[$];
   exp_t qb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bin2bcd_8421_seq #(.BIN_W(16), .DIGITS(5), .CNT_W(5)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
      .bin_in(bin_in_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
      .bcd_out(bcd_out_a), .out_ovf(out_ovf_a)
   );

   bin2bcd_8421_seq #(.BIN_W(8), .DIGITS(2), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
      .bin_in(bin_in_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
      .bcd_out(bcd_out_b), .out_ovf(out_ovf_b)
   );

   // Decimal reference: digit k is (v / 10**k) % 10; overflow when v >= 10**digits.
   function automatic exp_t model(input longint v, input int digits);
      exp_t   e;
      longint p = 1;
      e.bcd = '0;
      for (int k = 0; k < digits; k++) begin
         e.bcd = e.bcd | (20'((v / p) % 10) << (4 * k));
         p = p * 10;
      end
      e.ovf = (v >= p);
      e.val = v;
      e.acc = 0;
      return e;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_result(input string tag, input logic [19:0] act_bcd,
                               input logic act_ovf, input exp_t e, input int digits);
      chk($sformatf("%s ovf val=%0d", tag, e.val), act_ovf, e.ovf);
      if (!e.ovf) begin
         chk($sformatf("%s bcd val=%0d", tag, e.val), act_bcd, e.bcd);
         for (int k = 0; k < digits; k++)
            chk($sformatf("%s digit%0d<=9 val=%0d", tag, k, e.val),
                (act_bcd[4*k +: 4] <= 4'd9), 1);
      end
      $display("%s result: bin=%0d bcd=%h ovf=%0d", tag, e.val, act_bcd, act_ovf);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_va <= 1'b0;
         prev_vb <= 1'b0;
      end else begin
         if (in_valid_a && in_ready_a) begin
            e = model(longint'(bin_in_a), 5);
            e.acc = cyc + 1;
            qa.push_back(e);
         end
         if (in_valid_b && in_ready_b) begin
            e = model(longint'(bin_in_b), 2);
            e.acc = cyc + 1;
            qb.push_back(e);
         end
         if (out_valid_a && !prev_va && qa.size() > 0)
            chk("latency A", cyc - qa[0].acc, 16);
         if (out_valid_b && !prev_vb && qb.size() > 0)
            chk("latency B", cyc - qb[0].acc, 8);
         if (out_valid_a && out_ready_a) begin
            if (qa.size() == 0) chk("unexpected result A", 1, 0);
            else begin
               e = qa.pop_front();
               check_result("A", bcd_out_a, out_ovf_a, e, 5);
            end
         end
         if (out_valid_b && out_ready_b) begin
            if (qb.size() == 0) chk("unexpected result B", 1, 0);
            else begin
               e = qb.pop_front();
               check_result("B", {12'd0, bcd_out_b}, out_ovf_b, e, 2);
            end
         end
         prev_va <= out_valid_a;
         prev_vb <= out_valid_b;
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 out_ready_rnd = 1'($urandom_range(0, 1));
      end
   end

   task automatic send(input bit sel, input int v);
      bit ok = 1'b0;
      if (sel) begin bin_in_b = v[7:0];  in_valid_b = 1'b1; end
      else     begin bin_in_a = v[15:0]; in_valid_a = 1'b1; end
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         if (sel ? in_ready_b : in_ready_a) ok = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid_a = 1'b0;
      in_valid_b = 1'b0;
      bin_in_a   = 16'($urandom);
      bin_in_b   = 8'($urandom);
      if (!ok) chk("accept timeout", 0, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 200 && (qa.size() > 0 || qb.size() > 0); t++) @(posedge clk);
      chk("drain A", qa.size(), 0);
      chk("drain B", qb.size(), 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [19:0] snap;
      int          v;

      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset in_ready", in_ready_a, 1);
      chk("reset out_valid", out_valid_a, 0);
      chk("reset bcd_out", bcd_out_a, 0);
      chk("reset out_ovf", out_ovf_a, 0);
      chk("reset in_ready B", in_ready_b, 1);
      @(posedge clk);
      #1;

      // Directed corners
      send(0, 0);
      send(0, 65535);
      send(0, 9999);
      drain();

      // Backpressure in DONE, then in_valid together with out_ready
      out_ready_dir = 1'b0;
      send(0, 4095);
      for (int t = 0; t < 40 && !out_valid_a; t++) @(negedge clk);
      chk("wait out_valid", out_valid_a, 1);
      snap = bcd_out_a;
      for (int t = 0; t < 10; t++) begin
         @(posedge clk);
         #1 in_valid_a = 1'b1;
         bin_in_a = 16'd777;
         @(negedge clk);
         chk("bp bcd stable", bcd_out_a, snap);
         chk("bp in_ready", in_ready_a, 0);
         chk("bp out_valid", out_valid_a, 1);
      end
      @(posedge clk);
      #1 out_ready_dir = 1'b1;
      @(posedge clk);
      #1 in_valid_a = 1'b0;
      @(negedge clk);
      chk("post-bp in_ready", in_ready_a, 1);
      chk("post-bp out_valid", out_valid_a, 0);
      chk("post-bp bcd held", bcd_out_a, snap);
      @(posedge clk);
      #1;

      // Reset during SHIFT discards the conversion
      send(0, 4321);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      qa.delete();
      qb.delete();
      @(negedge clk);
      chk("mid-rst in_ready", in_ready_a, 1);
      chk("mid-rst out_valid", out_valid_a, 0);
      chk("mid-rst bcd_out", bcd_out_a, 0);
      @(posedge clk);
      #1;
      send(0, 1234);
      drain();

      // Narrow instance: 2 digits, 8-bit input
      send(1, 99);
      send(1, 100);
      send(1, 255);
      send(1, 0);
      for (int i = 0; i < 100; i++) send(1, $urandom_range(0, 255));
      drain();

      // Random traffic with random backpressure
      rand_mode = 1'b1;
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 15))
            0:       v = 0;
            1:       v = 65535;
            2:       v = 9999 + $urandom_range(0, 1);
            default: v = $urandom_range(0, 65535);
         endcase
         send(0, v);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end
      rand_mode = 1'b0;
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
      $fatal(1, "watchdog");
   end

endmodule
